// File: rtl/cache_mem_arbiter.sv
// Shares the single dataMemory port between the cache refill path (R, 128-bit block read)
// and the write path (W, 32-bit word write), hiding a fixed memory latency.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_W     = 128,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_ack,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_write_data,
    input  logic [BLOCK_W-1:0] mem_read_data,
    output logic               busy
);

    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic            OWN_R    = 1'b0;
    localparam logic            OWN_W    = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BLOCK_W-1:0] rd_data_q, rd_data_d;
    logic               rd_ack_q, rd_ack_d;
    logic               wr_ack_q, wr_ack_d;
    logic               mem_write_q, mem_write_d;
    logic               busy_q, busy_d;
    logic               grant_w;

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_R;
            last_grant_q <= OWN_W;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            rd_ack_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            rd_ack_q     <= rd_ack_d;
            wr_ack_q     <= wr_ack_d;
            mem_write_q  <= mem_write_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state: round-robin grant in IDLE, latency countdown in ACCESS.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        grant_w      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    grant_w      = wr_req && (!rd_req || (last_grant_q == OWN_R));
                    owner_d      = grant_w;
                    last_grant_d = grant_w;
                    cnt_d        = CNT_INIT;
                    addr_d       = grant_w ? wr_addr : rd_addr;
                    if (grant_w) begin
                        wdata_d = wr_data;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    if (owner_q == OWN_R) begin
                        rd_data_d = mem_read_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next-state values.
    always_comb begin
        mem_write_d = (state_d == ACCESS) && (cnt_d == '0) && (owner_d == OWN_W);
        rd_ack_d    = (state_d == ACK) && (owner_d == OWN_R);
        wr_ack_d    = (state_d == ACK) && (owner_d == OWN_W);
        busy_d      = (state_d != IDLE);
    end

    assign rd_ack         = rd_ack_q;
    assign wr_ack         = wr_ack_q;
    assign rd_data        = rd_data_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign busy           = busy_q;

endmodule
